// File: rtl/spi_memory_writer.sv
// SPI mode-0 slave that writes each received byte into sequential memory words.
// A zero byte terminates the stream; SPI inputs are oversampled in the clock domain.
module spi_memory_writer #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int START_ADDRESS = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  spi_clock,
    input  logic                  slave_select,
    input  logic                  mosi,
    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic                  finished,
    output logic                  overflow,
    output logic                  frame_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] START_PTR = ADDR_WIDTH'(START_ADDRESS);
    localparam logic [ADDR_WIDTH:0]   CAPACITY  = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - START_ADDRESS);

    typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_prev, rise, ss_q, mosi_q;

    logic [DATA_WIDTH-2:0]  shift;
    logic [CNT_W-1:0]       bit_count;
    logic [DATA_WIDTH-1:0]  byte_reg;
    logic [ADDR_WIDTH-1:0]  ptr;

    logic shift_en, byte_done, write_en, over_set, fin_set, abort, clear_count, full;

    // rise/ss_q/mosi_q are registered together so they stay cycle-aligned
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            rise      <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clock};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], slave_select};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            rise      <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            ss_q      <= ss_sync[SYNC_STAGES-1];
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    assign full = (byte_count == CAPACITY);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!ss_q) next_state = RECEIVE;
            RECEIVE: begin
                if (ss_q)                               next_state = IDLE;
                else if (rise && bit_count == LAST_BIT) next_state = WRITE;
            end
            WRITE: begin
                if (byte_reg == '0) next_state = DONE;
                else if (ss_q)      next_state = IDLE;
                else                next_state = RECEIVE;
            end
            default: next_state = DONE;
        endcase
    end

    // Deselect wins over a coincident edge; edges during WRITE start the next byte
    always_comb begin
        shift_en    = rise && !ss_q && (state == RECEIVE || state == WRITE);
        byte_done   = (state == RECEIVE) && shift_en && (bit_count == LAST_BIT);
        write_en    = (state == WRITE) && !full;
        over_set    = (state == WRITE) && full;
        fin_set     = (state == WRITE) && (byte_reg == '0);
        abort       = (state == RECEIVE) && ss_q && (bit_count != '0);
        clear_count = (state == IDLE) || ((state == RECEIVE) && ss_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift       <= '0;
            bit_count   <= '0;
            byte_reg    <= '0;
            ptr         <= START_PTR;
            byte_count  <= '0;
            mem_enable  <= 1'b0;
            mem_data    <= '0;
            finished    <= 1'b0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (shift_en) shift <= {shift[DATA_WIDTH-3:0], mosi_q};

            if (byte_done) begin
                byte_reg  <= {shift, mosi_q};
                bit_count <= '0;
            end else if (shift_en) begin
                bit_count <= bit_count + CNT_W'(1);
            end else if (clear_count) begin
                bit_count <= '0;
            end

            mem_enable <= write_en;
            if (write_en) mem_data <= byte_reg;

            // Pointer saturates at the top of memory rather than wrapping
            if (mem_enable) begin
                byte_count <= byte_count + (ADDR_WIDTH+1)'(1);
                if (ptr != '1) ptr <= ptr + ADDR_WIDTH'(1);
            end

            if (fin_set)  finished    <= 1'b1;
            if (over_set) overflow    <= 1'b1;
            if (abort)    frame_error <= 1'b1;
        end
    end

    assign mem_write_enable = mem_enable;
    assign mem_address      = ptr;

endmodule
